// File: rtl/rdregs_pkg.sv
// Shared types and helpers for the register-file SDPB front-end controller.
// Optional feature macro used by the controller: RDREGS_FWD_EN.
package rdregs_pkg;

    localparam int HAW_DEF       = 9;
    localparam int DW_DEF        = 16;
    localparam int STALL_MAX_DEF = 4;

    // IDLE  : buffer empty, client writes accepted
    // FETCH : partner half of the buffered word requested on port B
    // MERGE : partner half on ram_dout, merged word written on port A
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MERGE = 2'd2
    } state_t;

    // Insert data into the half selected by sel; partner fills the other half.
    function automatic logic [2*DW_DEF-1:0] merge_half(
        input logic [DW_DEF-1:0] partner,
        input logic [DW_DEF-1:0] data,
        input logic              sel
    );
        return sel ? {data, partner} : {partner, data};
    endfunction

endpackage

// File: rtl/rdregs_portb_arb.sv
// Port-B arbitration between client reads and the pending write's partner fetch.
// Client reads win port B until the fetch has lost STALL_MAX consecutive cycles;
// then the fetch is forced through and rd_ready drops for that one cycle.
module rdregs_portb_arb #(
    parameter int HAW       = 9,
    parameter int STALL_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fetch_pend,
    input  logic [HAW-1:0] fetch_adb,
    input  logic           rd_req,
    input  logic [HAW-1:0] rd_addr,
    input  logic           rd_hold,
    input  logic           rd_fwd,
    output logic           rd_ready,
    output logic           rd_acc,
    output logic           fetch_go,
    output logic           ram_ceb,
    output logic [HAW-1:0] ram_adb
);

    localparam int SW = $clog2(STALL_MAX + 1);

    logic [SW-1:0] stall;
    logic          stall_full;
    logic          rd_port;

    assign stall_full = (stall == SW'(STALL_MAX));
    assign rd_ready   = !rd_hold && !(fetch_pend && stall_full);
    assign rd_acc     = rd_req && rd_ready;
    // A forwarded read is served from the write buffer and leaves port B free.
    assign rd_port    = rd_acc && !rd_fwd;
    assign fetch_go   = fetch_pend && !rd_port;

    // Port-B command: client read has priority, otherwise the pending fetch.
    always_comb begin
        ram_ceb = 1'b0;
        ram_adb = '0;
        if (rd_port) begin
            ram_ceb = 1'b1;
            ram_adb = rd_addr;
        end else if (fetch_go) begin
            ram_ceb = 1'b1;
            ram_adb = fetch_adb;
        end
    end

    // Count cycles the fetch loses to reads; clear once the fetch issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall <= '0;
        end else if (!fetch_pend || fetch_go) begin
            stall <= '0;
        end else if (rd_port) begin
            stall <= stall + SW'(1);
        end
    end

endmodule

// File: rtl/rdregs_rmw_ctrl.sv
// Front-end controller for the 256x32-write / 512x16-read register-file SDPB.
// Serialises client reads on port B and turns each 16-bit client write into a
// read-modify-write of the 32-bit port-A word.
// Optional feature macro: RDREGS_FWD_EN (forward buffered write data to a read
// of the same halfword while the write is in flight).
//
// state | meaning
// IDLE  | write buffer empty; wr_ready high
// FETCH | partner half being fetched on port B (may lose port B to reads)
// MERGE | merged word committed on port A
module rdregs_rmw_ctrl
    import rdregs_pkg::*;
#(
    parameter int HAW       = HAW_DEF,
    parameter int DW        = DW_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_req,
    input  logic [HAW-1:0]  wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_ready,
    input  logic            rd_req,
    input  logic [HAW-1:0]  rd_addr,
    output logic            rd_ready,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            ram_cea,
    output logic [HAW-2:0]  ram_ada,
    output logic [2*DW-1:0] ram_din,
    output logic            ram_ceb,
    output logic [HAW-1:0]  ram_adb,
    output logic            ram_oce,
    input  logic [DW-1:0]   ram_dout
);

    state_t         state, state_nxt;
    logic [HAW-1:0] buf_addr;
    logic [DW-1:0]  buf_data;
    logic           wr_acc;
    logic           hazard_word;
    logic           rd_hold;
    logic           rd_fwd;
    logic           rd_acc;
    logic           fetch_go;
    logic           fwd_q;
    logic [DW-1:0]  fwd_data;

    assign ram_oce  = 1'b1;
    assign wr_ready = (state == IDLE);
    assign wr_acc   = wr_req && wr_ready;

    // A read touching the buffered word while the RMW is in flight.
    assign hazard_word = (state != IDLE) && (rd_addr[HAW-1:1] == buf_addr[HAW-1:1]);

`ifdef RDREGS_FWD_EN
    assign rd_hold = 1'b0;
    assign rd_fwd  = hazard_word && (rd_addr[0] == buf_addr[0]);
`else
    assign rd_hold = hazard_word;
    assign rd_fwd  = 1'b0;
`endif

    rdregs_portb_arb #(
        .HAW       (HAW),
        .STALL_MAX (STALL_MAX)
    ) u_portb_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_pend (state == FETCH),
        .fetch_adb  ({buf_addr[HAW-1:1], ~buf_addr[0]}),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_hold    (rd_hold),
        .rd_fwd     (rd_fwd),
        .rd_ready   (rd_ready),
        .rd_acc     (rd_acc),
        .fetch_go   (fetch_go),
        .ram_ceb    (ram_ceb),
        .ram_adb    (ram_adb)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and port-A commit of the merged word.
    always_comb begin
        state_nxt = state;
        ram_cea   = 1'b0;
        ram_ada   = '0;
        ram_din   = '0;
        case (state)
            IDLE: begin
                if (wr_acc) state_nxt = FETCH;
            end
            FETCH: begin
                if (fetch_go) state_nxt = MERGE;
            end
            MERGE: begin
                ram_cea   = 1'b1;
                ram_ada   = buf_addr[HAW-1:1];
                ram_din   = merge_half(ram_dout, buf_data, buf_addr[0]);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-entry write buffer, loaded on the accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_addr <= '0;
            buf_data <= '0;
        end else if (wr_acc) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
        end
    end

    // Read response tracking: valid one cycle after accept, with forward select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            fwd_q    <= 1'b0;
            fwd_data <= '0;
        end else begin
            rd_valid <= rd_acc;
            fwd_q    <= rd_acc && rd_fwd;
            fwd_data <= buf_data;
        end
    end

    assign rd_data = rd_valid ? (fwd_q ? fwd_data : ram_dout) : '0;

endmodule
